// File: rtl/pkt_dect_mc.sv
// pkt_dect_mc: multi-channel packet-envelope detector with input sync, entry filter and hang time.
// Define PKT_TIMEOUT_EN to force a packet exit (LOCK state) once its length reaches MAX_LEN.
module pkt_dect_mc #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ENTRY_CNT   = 4,
  parameter int CNT_W       = 16,
  parameter int LEN_W       = 16,
  parameter int MAX_LEN     = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       dect_in,
  input  logic [CNT_W-1:0]      hold_cyc,
  output logic [N_CH-1:0]       dect_out,
  output logic                  any_dect,
  output logic [N_CH-1:0]       pkt_start,
  output logic [N_CH-1:0]       pkt_end,
  output logic [N_CH-1:0]       timeout_out,
  output logic [N_CH*LEN_W-1:0] len_out
);
`ifdef PKT_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ARM, PKT, HANG, LOCK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ARM, PKT, HANG} state_t;
`endif
  localparam logic [CNT_W-1:0] ENTRY_M1 = CNT_W'(ENTRY_CNT - 1);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  logic [CNT_W-1:0] hold_m1;
  if (SYNC_STAGES < 2 || ENTRY_CNT < 1 || MAX_LEN < 1) begin : g_bad_cfg
    $error("pkt_dect_mc: invalid parameter set");
  end
  // a hold time of 0 behaves as 1
  assign hold_m1 = (hold_cyc == '0) ? '0 : hold_cyc - CNT_W'(1);
  assign any_dect = |dect_out;
`ifndef PKT_TIMEOUT_EN
  assign timeout_out = '0;
`endif
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t st;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] last;
    logic s;
    logic start;
    logic fin;
    assign s = sync[SYNC_STAGES-1];
    assign dect_out[g] = (st == PKT) || (st == HANG);
    assign pkt_start[g] = start;
    assign pkt_end[g] = fin;
    assign len_out[g*LEN_W +: LEN_W] = last;
`ifdef PKT_TIMEOUT_EN
    logic tmo;
    assign timeout_out[g] = tmo;
`endif
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        sync <= '0;
        st <= IDLE;
        cnt <= '0;
        len <= '0;
        last <= '0;
        start <= 1'b0;
        fin <= 1'b0;
`ifdef PKT_TIMEOUT_EN
        tmo <= 1'b0;
`endif
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], dect_in[g]};
        start <= 1'b0;
        fin <= 1'b0;
`ifdef PKT_TIMEOUT_EN
        tmo <= 1'b0;
`endif
        case (st)
          IDLE: if (s) begin
            len <= LEN_W'(1);
            start <= (ENTRY_CNT == 1);
            st <= (ENTRY_CNT == 1) ? PKT : ARM;
            cnt <= CNT_W'(1);
          end
          ARM: if (!s) begin
            st <= IDLE;
            cnt <= '0;
          end else if (cnt >= ENTRY_M1) begin
            st <= PKT;
            start <= 1'b1;
            len <= LEN_W'(1);
          end else cnt <= cnt + CNT_W'(1);
          PKT, HANG: begin
            len <= (len == LEN_SAT) ? len : len + LEN_W'(1);
`ifdef PKT_TIMEOUT_EN
            if (len == LEN_W'(MAX_LEN)) begin
              st <= LOCK;
              fin <= 1'b1;
              tmo <= 1'b1;
              last <= len;
            end else
`endif
            if (s) st <= PKT;
            else if (st == PKT) begin
              st <= HANG;
              cnt <= '0;
            end else if (cnt < hold_m1) cnt <= cnt + CNT_W'(1);
            else begin
              st <= IDLE;
              fin <= 1'b1;
              last <= len;
            end
          end
`ifdef PKT_TIMEOUT_EN
          LOCK: if (!s) st <= IDLE;
`endif
          default: st <= IDLE;
        endcase
      end
  end
endmodule

// File: tb/tb_pkt_dect_mc.sv
// tb_pkt_dect_mc: directed and randomized bench for pkt_dect_mc against a run-length reference model.
module tb_pkt_dect_mc;
  localparam int N = 4, SS = 2, EC = 4, CW = 16, LW = 8;
  localparam int SAT = (1 << LW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] din = '0;
  logic [CW-1:0] hold = 16'd5;
  logic [N-1:0] dect_out, pkt_start, pkt_end, timeout_out;
  logic any_dect;
  logic [N*LW-1:0] len_out;
  int checks = 0, errors = 0;
  logic [N-1:0] pipe [SS];
  bit m_in [N];
  int hi_run [N], lo_run [N], m_len [N], m_last [N];
  logic [N-1:0] m_start, m_end;
  int n_start [N], n_end [N], n_high [N];
  int n_any, rise;

  pkt_dect_mc #(.N_CH(N), .SYNC_STAGES(SS), .ENTRY_CNT(EC), .CNT_W(CW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .dect_in(din), .hold_cyc(hold), .dect_out(dect_out),
    .any_dect(any_dect), .pkt_start(pkt_start), .pkt_end(pkt_end),
    .timeout_out(timeout_out), .len_out(len_out));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < SS; k++) pipe[k] = '0;
    for (int i = 0; i < N; i++) begin
      m_in[i] = 0; hi_run[i] = 0; lo_run[i] = 0; m_len[i] = 0; m_last[i] = 0;
    end
    m_start = '0;
    m_end = '0;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < N; i++) begin
      n_start[i] = 0; n_end[i] = 0; n_high[i] = 0;
    end
    n_any = 0;
  endtask

  // packet = ENTRY consecutive high samples; ends after 1+max(hold,1) consecutive lows
  task automatic model_edge();
    int hmax;
    hmax = (hold == 0) ? 1 : int'(hold);
    for (int i = 0; i < N; i++) begin
      bit s;
      s = pipe[SS-1][i];
      m_start[i] = 1'b0;
      m_end[i] = 1'b0;
      if (!m_in[i]) begin
        hi_run[i] = s ? hi_run[i] + 1 : 0;
        if (hi_run[i] >= EC) begin
          m_in[i] = 1; m_start[i] = 1'b1; m_len[i] = 1; lo_run[i] = 0; hi_run[i] = 0;
        end
      end else begin
        lo_run[i] = s ? 0 : lo_run[i] + 1;
        if (lo_run[i] >= hmax + 1) begin
          m_in[i] = 0; m_end[i] = 1'b1; m_last[i] = m_len[i];
        end else if (m_len[i] < SAT) m_len[i]++;
      end
    end
    for (int k = SS - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0] = din;
  endtask

  task automatic compare_all();
    logic [N-1:0] e_dect;
    logic [N*LW-1:0] e_len;
    for (int i = 0; i < N; i++) begin
      e_dect[i] = m_in[i];
      e_len[i*LW +: LW] = LW'(m_last[i]);
    end
    chk("dect_out", dect_out, e_dect);
    chk("any_dect", any_dect, |e_dect);
    chk("pkt_start", pkt_start, m_start);
    chk("pkt_end", pkt_end, m_end);
    chk("timeout_out", timeout_out, '0);
    chk("len_out", len_out, e_len);
    for (int i = 0; i < N; i++) begin
      n_start[i] += int'(pkt_start[i]);
      n_end[i] += int'(pkt_end[i]);
      n_high[i] += int'(dect_out[i]);
    end
    n_any += int'(any_dect);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(input logic [N-1:0] v, input int n);
    din = v;
    repeat (n) tick();
  endtask

  initial begin
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;
    // short glitch never becomes a packet
    run(4'b0001, 3);
    run(4'b0000, 12);
    chk("t1_starts", n_start[0], 0);
    chk("t1_ends", n_end[0], 0);
    // single packet: latency and length
    clear_stats();
    rise = -1;
    din = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (rise < 0 && dect_out[0]) rise = k;
    end
    run(4'b0000, 20);
    chk("t2_latency", rise, 6);
    chk("t2_high", n_high[0], 12);
    chk("t2_starts", n_start[0], 1);
    chk("t2_ends", n_end[0], 1);
    chk("t2_len", len_out[7:0], 12);
    // bridged gap, then a gap too long to bridge
    clear_stats();
    run(4'b0001, 10); run(4'b0000, 3); run(4'b0001, 10); run(4'b0000, 20);
    chk("t3a_starts", n_start[0], 1);
    chk("t3a_ends", n_end[0], 1);
    chk("t3a_len", len_out[7:0], 25);
    clear_stats();
    run(4'b0001, 10); run(4'b0000, 7); run(4'b0001, 10); run(4'b0000, 20);
    chk("t3b_starts", n_start[0], 2);
    chk("t3b_ends", n_end[0], 2);
    chk("t3b_len", len_out[7:0], 12);
    // simultaneous channels with hold 0
    hold = 16'd0;
    clear_stats();
    run(4'b1010, 10);
    run(4'b0000, 10);
    chk("t4_start1", n_start[1], 1);
    chk("t4_start3", n_start[3], 1);
    chk("t4_len1", len_out[15:8], 8);
    chk("t4_len3", len_out[31:24], 8);
    chk("t4_any", n_any, 8);
    // reset mid-packet
    hold = 16'd5;
    clear_stats();
    rise = -1;
    din = 4'b0100;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      tick();
      if (dect_out[2]) rise = k;
    end
    chk("t5_rise", rise, 6);
    run(4'b0100, 5);
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("t5_len_zero", len_out, 0);
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    rise = -1;
    for (int k = 1; k <= 20 && rise < 0; k++) begin
      tick();
      if (dect_out[2]) rise = k;
    end
    chk("t5_rerise", rise, EC + SS);
    chk("t5_no_end", n_end[2], 0);
    run(4'b0000, 20);
    chk("t5_end", n_end[2], 1);
    // length saturation
    hold = 16'd3;
    clear_stats();
    run(4'b1000, 300);
    run(4'b0000, 20);
    chk("t6_len_sat", len_out[31:24], SAT);
    chk("t6_ends", n_end[3], 1);
    // randomized traffic with occasional hold changes
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) hold = CW'($urandom_range(0, 6));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
      tick();
    end
    run(4'b0000, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
